// File: rtl/cvita_ramp_pkt_checker_pkg.sv
// Shared constants for the CHDR ramp packet checker: header fields, settings
// offsets, error-flag bits and the receive FSM states.
package cvita_chk_pkg;

  localparam int HDR_HAS_TIME = 61;
  localparam int HDR_SEQ_LSB  = 48;
  localparam int HDR_SEQ_W    = 12;
  localparam int HDR_LEN_LSB  = 32;
  localparam int HDR_LEN_W    = 16;
  localparam int HDR_SID_LSB  = 0;
  localparam int HDR_SID_W    = 32;

  localparam int SR_CTRL      = 0;
  localparam int SR_EXP_SID   = 1;
  localparam int SR_EXP_WORDS = 2;
  localparam int SR_STEP      = 3;

  localparam int CTRL_ENABLE  = 0;
  localparam int CTRL_CLEAR   = 1;
  localparam int CTRL_CHK_SEQ = 2;
  localparam int CTRL_CHK_SID = 3;

  localparam int ERR_LEN  = 0;
  localparam int ERR_SID  = 1;
  localparam int ERR_SEQ  = 2;
  localparam int ERR_DATA = 3;

  typedef enum logic [1:0] {
    ST_HDR     = 2'd0,
    ST_TIME    = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_t;

  // Byte length a well-formed packet must advertise (header + optional time + payload).
  function automatic logic [15:0] exp_len_bytes(input logic has_time, input logic [15:0] words);
    logic [15:0] beats;
    beats = words + {15'd0, has_time} + 16'd1;
    return {beats[12:0], 3'b000};
  endfunction

endpackage

// File: rtl/cvita_ramp_pkt_checker_if.sv
// CHDR stream bundle carried into the ramp packet checker.
interface cvita_ramp_pkt_checker_if;
  logic [63:0] i_tdata;
  logic        i_tlast;
  logic        i_tvalid;
  logic        i_tready;

  modport master (output i_tdata, output i_tlast, output i_tvalid, input i_tready);
  modport slave  (input i_tdata, input i_tlast, input i_tvalid, output i_tready);
endinterface

// File: rtl/cvita_ramp_pkt_checker_sat.sv
// 32-bit event counter with synchronous clear that sticks at all-ones.
module sat_counter32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc,
  output logic [31:0] count
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != 32'hFFFF_FFFF)) begin
      count <= count + 32'd1;
    end
  end
endmodule

// File: rtl/cvita_ramp_pkt_checker.sv
// CHDR sink that checks SID, length, sequence and ramp payload of each packet
// and exposes packet/error counters over the settings/readback bus.
module cvita_ramp_pkt_checker
  import cvita_chk_pkg::*;
#(
  parameter int SR_BASE   = 0,
  parameter int SR_AWIDTH = 8
) (
  input  logic                 bus_clk,
  input  logic                 bus_rst_n,
  cvita_ramp_pkt_checker_if.slave chdr,
  input  logic                 set_stb,
  input  logic [SR_AWIDTH-1:0] set_addr,
  input  logic [31:0]          set_data,
  input  logic [1:0]           rb_addr,
  output logic [63:0]          rb_data,
  output logic                 err_stb
);
  localparam logic [SR_AWIDTH-1:0] A_CTRL  = SR_AWIDTH'(SR_BASE + SR_CTRL);
  localparam logic [SR_AWIDTH-1:0] A_SID   = SR_AWIDTH'(SR_BASE + SR_EXP_SID);
  localparam logic [SR_AWIDTH-1:0] A_WORDS = SR_AWIDTH'(SR_BASE + SR_EXP_WORDS);
  localparam logic [SR_AWIDTH-1:0] A_STEP  = SR_AWIDTH'(SR_BASE + SR_STEP);

  logic        enable, chk_seq, chk_sid, clear;
  logic [31:0] exp_sid, step;
  logic [15:0] exp_words;

  assign clear = set_stb && (set_addr == A_CTRL) && set_data[CTRL_CLEAR];

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      enable    <= 1'b0;
      chk_seq   <= 1'b0;
      chk_sid   <= 1'b0;
      exp_sid   <= '0;
      exp_words <= '0;
      step      <= '0;
    end else if (set_stb) begin
      if (set_addr == A_CTRL) begin
        enable  <= set_data[CTRL_ENABLE];
        chk_seq <= set_data[CTRL_CHK_SEQ];
        chk_sid <= set_data[CTRL_CHK_SID];
      end
      if (set_addr == A_SID)   exp_sid   <= set_data;
      if (set_addr == A_WORDS) exp_words <= set_data[15:0];
      if (set_addr == A_STEP)  step      <= set_data;
    end
  end

  logic rdy;
  logic beat;
  assign chdr.i_tready = rdy;
  assign beat          = chdr.i_tvalid && rdy;

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) rdy <= 1'b0;
    else            rdy <= 1'b1;
  end

  state_t state, state_nxt;

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) state <= ST_HDR;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (beat) begin
      case (state)
        ST_HDR:     if (!chdr.i_tlast) state_nxt = chdr.i_tdata[HDR_HAS_TIME] ? ST_TIME : ST_PAYLOAD;
        ST_TIME:    state_nxt = chdr.i_tlast ? ST_HDR : ST_PAYLOAD;
        ST_PAYLOAD: if (chdr.i_tlast) state_nxt = ST_HDR;
        default:    state_nxt = ST_HDR;
      endcase
    end
  end

  logic                 pkt_en, seq_seeded;
  logic [3:0]           pkt_err;
  logic [15:0]          widx, bad_idx;
  logic [63:0]          exp_val, hdr_word;
  logic [HDR_SEQ_W-1:0] prev_seq;

  logic                 has_time_in;
  logic [HDR_SEQ_W-1:0] seq_in;
  logic [HDR_LEN_W-1:0] len_in;
  logic [HDR_SID_W-1:0] sid_in;
  logic                 data_mis, pkt_en_now, len_end;
  logic [3:0]           hdr_flags, sticky_nxt, eval_flags;
  logic [15:0]          idx_nxt;

  assign has_time_in = chdr.i_tdata[HDR_HAS_TIME];
  assign seq_in      = chdr.i_tdata[HDR_SEQ_LSB +: HDR_SEQ_W];
  assign len_in      = chdr.i_tdata[HDR_LEN_LSB +: HDR_LEN_W];
  assign sid_in      = chdr.i_tdata[HDR_SID_LSB +: HDR_SID_W];
  assign data_mis    = chdr.i_tdata != exp_val;
  assign pkt_en_now  = (state == ST_HDR) ? enable : pkt_en;

  // Sticky per-packet flags; LEN from the word count is only known at tlast.
  always_comb begin
    hdr_flags           = '0;
    hdr_flags[ERR_LEN]  = len_in != exp_len_bytes(has_time_in, exp_words);
    hdr_flags[ERR_SID]  = chk_sid && (sid_in != exp_sid);
    hdr_flags[ERR_SEQ]  = chk_seq && seq_seeded && (seq_in != HDR_SEQ_W'(prev_seq + 12'd1));
    sticky_nxt = pkt_err;
    idx_nxt    = bad_idx;
    len_end    = 1'b0;
    case (state)
      ST_HDR: begin
        sticky_nxt = hdr_flags;
        idx_nxt    = '0;
        len_end    = 1'b1;
      end
      ST_TIME: len_end = exp_words != 16'd0;
      ST_PAYLOAD: begin
        if (data_mis && !pkt_err[ERR_DATA]) begin
          sticky_nxt[ERR_DATA] = 1'b1;
          idx_nxt              = widx;
        end
        len_end = ({1'b0, widx} + 17'd1) != {1'b0, exp_words};
      end
      default: ;
    endcase
    eval_flags          = sticky_nxt;
    eval_flags[ERR_LEN] = sticky_nxt[ERR_LEN] | len_end;
  end

  logic        vld_p1;
  logic [3:0]  flags_p1;
  logic [15:0] idx_p1;
  logic [63:0] hdr_p1;

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      pkt_en     <= 1'b0;
      pkt_err    <= '0;
      widx       <= '0;
      bad_idx    <= '0;
      exp_val    <= '0;
      hdr_word   <= '0;
      prev_seq   <= '0;
      seq_seeded <= 1'b0;
      vld_p1     <= 1'b0;
      flags_p1   <= '0;
      idx_p1     <= '0;
      hdr_p1     <= '0;
    end else begin
      if (beat) begin
        case (state)
          ST_HDR: begin
            pkt_en   <= enable;
            pkt_err  <= sticky_nxt;
            bad_idx  <= '0;
            widx     <= '0;
            exp_val  <= '0;
            hdr_word <= chdr.i_tdata;
            if (enable) begin
              prev_seq   <= seq_in;
              seq_seeded <= 1'b1;
            end else begin
              seq_seeded <= 1'b0;
            end
          end
          ST_PAYLOAD: begin
            pkt_err <= sticky_nxt;
            bad_idx <= idx_nxt;
            exp_val <= exp_val + {32'd0, step};
            if (widx != 16'hFFFF) widx <= widx + 16'd1;
          end
          default: ;
        endcase
      end
      if (clear) seq_seeded <= 1'b0;
      // ---- stage p1: packet verdict captured at tlast ----
      vld_p1   <= beat && chdr.i_tlast && pkt_en_now && !clear;
      flags_p1 <= eval_flags;
      idx_p1   <= idx_nxt;
      hdr_p1   <= (state == ST_HDR) ? chdr.i_tdata : hdr_word;
    end
  end

  // ---- stage p2: counters, flags and strobe ----
  logic        upd, fail;
  logic [31:0] pkt_count, err_count;
  logic [3:0]  last_flags;
  logic [15:0] first_bad_idx;
  logic [63:0] last_hdr;

  assign upd  = vld_p1 && !clear;
  assign fail = upd && (flags_p1 != 4'd0);

  sat_counter32 u_pkt_cnt (.clk(bus_clk), .rst_n(bus_rst_n), .clr(clear), .inc(upd),  .count(pkt_count));
  sat_counter32 u_err_cnt (.clk(bus_clk), .rst_n(bus_rst_n), .clr(clear), .inc(fail), .count(err_count));

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      err_stb       <= 1'b0;
      last_flags    <= '0;
      first_bad_idx <= '0;
      last_hdr      <= '0;
      rb_data       <= '0;
    end else begin
      err_stb <= fail;
      if (clear) begin
        last_flags    <= '0;
        first_bad_idx <= '0;
      end else if (fail) begin
        last_flags    <= flags_p1;
        first_bad_idx <= idx_p1;
      end
      if (upd) last_hdr <= hdr_p1;
      case (rb_addr)
        2'd0:    rb_data <= {32'd0, pkt_count};
        2'd1:    rb_data <= {32'd0, err_count};
        2'd2:    rb_data <= {44'd0, last_flags, first_bad_idx};
        default: rb_data <= last_hdr;
      endcase
    end
  end

endmodule

// File: tb/tb_cvita_ramp_pkt_checker.sv
// Directed bench for the ramp packet checker: stimulus pushes expected error
// events into a queue that a separate monitor drains on every err_stb pulse.
module tb_cvita_ramp_pkt_checker;
  logic        bus_clk = 1'b0;
  logic        bus_rst_n = 1'b0;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = '0;
  logic [31:0] set_data = '0;
  logic [1:0]  rb_addr = 2'd2;
  logic [63:0] rb_data;
  logic        err_stb;

  int checks = 0;
  int errors = 0;
  int rdy_drops = 0;
  bit rdy_watch = 1'b0;
  logic [19:0] exp_q[$];

  cvita_ramp_pkt_checker_if chdr();

  cvita_ramp_pkt_checker #(.SR_BASE(0), .SR_AWIDTH(8)) dut (
    .bus_clk(bus_clk), .bus_rst_n(bus_rst_n), .chdr(chdr),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .rb_addr(rb_addr), .rb_data(rb_data), .err_stb(err_stb)
  );

  always #5 bus_clk = ~bus_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk_hdr(input bit ht, input logic [11:0] seq,
                                         input logic [15:0] len, input logic [31:0] sid);
    return {2'b00, ht, 1'b0, seq, len, sid};
  endfunction

  task automatic set_reg(input logic [7:0] a, input logic [31:0] d);
    set_stb = 1'b1; set_addr = a; set_data = d;
    @(negedge bus_clk);
    set_stb = 1'b0;
  endtask

  task automatic beat(input logic [63:0] d, input bit last);
    chdr.i_tdata = d; chdr.i_tlast = last; chdr.i_tvalid = 1'b1;
    @(negedge bus_clk);
  endtask

  task automatic idle(input int n);
    chdr.i_tvalid = 1'b0; chdr.i_tlast = 1'b0;
    repeat (n) @(negedge bus_clk);
  endtask

  // Ramp payload k*0x100; bad_word >= 0 flips bit 0 of that word.
  task automatic send_pkt(input bit ht, input logic [11:0] seq, input logic [15:0] len,
                          input logic [31:0] sid, input int nwords, input int bad_word,
                          input bit b2b, input bit clr_last);
    logic [63:0] w;
    beat(mk_hdr(ht, seq, len, sid), nwords == 0 && !ht);
    if (ht) beat(64'hDEAD_BEEF_0000_0001, nwords == 0);
    for (int k = 0; k < nwords; k++) begin
      w = 64'(k) * 64'h100;
      if (k == bad_word) w = w ^ 64'd1;
      if (clr_last && k == nwords - 1) begin
        set_stb = 1'b1; set_addr = 8'd0; set_data = 32'h3;
      end
      beat(w, k == nwords - 1);
      set_stb = 1'b0;
    end
    if (!b2b) idle(1);
  endtask

  task automatic expect_err(input logic [3:0] flags, input logic [15:0] idx);
    exp_q.push_back({flags, idx});
  endtask

  task automatic rd(input string name, input logic [1:0] a, input logic [63:0] exp);
    rb_addr = a;
    @(posedge bus_clk); #1;
    chk(name, rb_data, exp);
    @(negedge bus_clk);
    rb_addr = 2'd2;
  endtask

  // Monitor: every err_stb pulse must match the oldest expected error event.
  initial begin
    logic [19:0] e;
    forever begin
      @(posedge bus_clk); #1;
      if (rdy_watch && !chdr.i_tready) rdy_drops++;
      if (err_stb) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_err_stb", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          @(posedge bus_clk); #1;
          chk("err_flags_idx", {44'd0, rb_data[19:0]}, {44'd0, e});
          chk("err_stb_single", {63'd0, err_stb}, 64'd0);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    chdr.i_tdata = '0; chdr.i_tlast = 1'b0; chdr.i_tvalid = 1'b0;
    repeat (3) @(negedge bus_clk);
    chk("rst_tready", {63'd0, chdr.i_tready}, 64'd0);
    chk("rst_rb_data", rb_data, 64'd0);
    chk("rst_err_stb", {63'd0, err_stb}, 64'd0);
    bus_rst_n = 1'b1;
    @(posedge bus_clk); #1;
    chk("tready_after_rst", {63'd0, chdr.i_tready}, 64'd1);
    @(negedge bus_clk);

    // Clean run
    set_reg(8'd2, 32'd16);
    set_reg(8'd3, 32'h100);
    set_reg(8'd0, 32'h1);
    for (int p = 0; p < 10; p++) send_pkt(1'b0, 12'(p), 16'h88, 32'h0, 16, -1, 1'b0, 1'b0);
    idle(4);
    rd("clean_pkt_count", 2'd0, 64'd10);
    rd("clean_err_count", 2'd1, 64'd0);

    // Payload corruption in the third packet, word 5
    set_reg(8'd0, 32'h3);
    for (int p = 0; p < 5; p++) begin
      if (p == 2) expect_err(4'b1000, 16'd5);
      send_pkt(1'b0, 12'(p), 16'h88, 32'h0, 16, (p == 2) ? 5 : -1, 1'b0, 1'b0);
    end
    idle(4);
    rd("corrupt_pkt_count", 2'd0, 64'd5);
    rd("corrupt_err_count", 2'd1, 64'd1);

    // Length errors: short packet, wrong length field, header-only packet
    set_reg(8'd0, 32'h3);
    expect_err(4'b0001, 16'd0);
    send_pkt(1'b0, 12'd0, 16'h80, 32'h0, 15, -1, 1'b0, 1'b0);
    idle(3);
    expect_err(4'b0001, 16'd0);
    send_pkt(1'b0, 12'd1, 16'h90, 32'h0, 16, -1, 1'b0, 1'b0);
    idle(4);
    rd("len_err_count", 2'd1, 64'd2);
    rd("len_pkt_count", 2'd0, 64'd2);
    expect_err(4'b0001, 16'd0);
    send_pkt(1'b0, 12'd2, 16'h88, 32'h0, 0, -1, 1'b0, 1'b0);
    idle(4);
    rd("hdr_only_err_count", 2'd1, 64'd3);

    // SID and sequence wrap
    set_reg(8'd1, 32'h1234_5678);
    set_reg(8'd0, 32'hF);
    send_pkt(1'b0, 12'hFFE, 16'h88, 32'h1234_5678, 16, -1, 1'b0, 1'b0);
    send_pkt(1'b0, 12'hFFF, 16'h88, 32'h1234_5678, 16, -1, 1'b0, 1'b0);
    send_pkt(1'b0, 12'h000, 16'h88, 32'h1234_5678, 16, -1, 1'b0, 1'b0);
    idle(4);
    rd("seq_wrap_err_count", 2'd1, 64'd0);
    expect_err(4'b0100, 16'd0);
    send_pkt(1'b0, 12'h002, 16'h88, 32'h1234_5678, 16, -1, 1'b0, 1'b0);
    idle(3);
    expect_err(4'b0010, 16'd0);
    send_pkt(1'b0, 12'h003, 16'h88, 32'h1234_5679, 16, -1, 1'b0, 1'b0);
    idle(4);
    rd("sidseq_pkt_count", 2'd0, 64'd5);
    rd("sidseq_err_count", 2'd1, 64'd2);

    // Timestamped packets back-to-back
    set_reg(8'd0, 32'h3);
    rdy_watch = 1'b1;
    for (int p = 0; p < 4; p++) send_pkt(1'b1, 12'(p), 16'h90, 32'h0, 16, -1, 1'b1, 1'b0);
    idle(4);
    rdy_watch = 1'b0;
    chk("tready_held", 64'(rdy_drops), 64'd0);
    rd("ts_pkt_count", 2'd0, 64'd4);
    rd("ts_err_count", 2'd1, 64'd0);
    rd("ts_last_hdr", 2'd3, mk_hdr(1'b1, 12'd3, 16'h90, 32'h0));

    // Clear coincident with a failing packet's tlast
    send_pkt(1'b0, 12'd4, 16'h88, 32'h0, 16, -1, 1'b0, 1'b0);
    send_pkt(1'b0, 12'd5, 16'h80, 32'h0, 15, -1, 1'b0, 1'b1);
    idle(4);
    rd("clr_pkt_count", 2'd0, 64'd0);
    rd("clr_err_count", 2'd1, 64'd0);

    // Reset mid-packet
    send_pkt(1'b0, 12'd6, 16'h88, 32'h0, 16, -1, 1'b0, 1'b0);
    idle(3);
    rb_addr = 2'd0;
    beat(mk_hdr(1'b0, 12'd7, 16'h88, 32'h0), 1'b0);
    for (int k = 0; k < 8; k++) beat(64'(k) * 64'h100, 1'b0);
    chdr.i_tvalid = 1'b0;
    bus_rst_n = 1'b0;
    #1;
    chk("midrst_tready", {63'd0, chdr.i_tready}, 64'd0);
    chk("midrst_rb_data", rb_data, 64'd0);
    chk("midrst_err_stb", {63'd0, err_stb}, 64'd0);
    @(negedge bus_clk);
    @(negedge bus_clk);
    bus_rst_n = 1'b1;
    rb_addr = 2'd2;
    @(negedge bus_clk);
    set_reg(8'd2, 32'd16);
    set_reg(8'd3, 32'h100);
    set_reg(8'd0, 32'h1);
    expect_err(4'b1001, 16'd0);
    for (int k = 8; k < 16; k++) beat(64'(k) * 64'h100, k == 15);
    idle(3);
    send_pkt(1'b0, 12'd8, 16'h88, 32'h0, 16, -1, 1'b0, 1'b0);
    idle(4);
    rd("post_rst_pkt_count", 2'd0, 64'd2);
    rd("post_rst_err_count", 2'd1, 64'd1);

    idle(3);
    chk("pending_err_events", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cvita_ramp_pkt_checker.md
# cvita_ramp_pkt_checker

Synthesizable CVITA (CHDR) packet sink that checks ramp-payload packets coming out of a buffering path such as the DRAM FIFO. It validates each packet's header SID, header length field, payload word count, optional sequence number and ramp payload contents. It accumulates packet and error counters that software reads over the settings/readback bus. It is the receive-side counterpart of the ramp packet generator and supports on-hardware soak tests of the FIFO without a simulator-side slave.

## Interface
Parameters:
- SR_BASE, 0: settings-bus base address; registers occupy SR_BASE+0..+3.
- SR_AWIDTH, 8: settings address width.

Ports:
- bus_clk  in  1  sole clock.
- bus_rst_n  in  1  reset, asynchronous, active-low.
- i_tdata  in  64  CHDR stream data.
- i_tlast  in  1  last beat of packet.
- i_tvalid  in  1  beat valid.
- i_tready  out  1  beat accept.
- set_stb  in  1  settings write strobe.
- set_addr  in  SR_AWIDTH  settings address.
- set_data  in  32  settings data.
- rb_addr  in  2  readback select.
- rb_data  out  64  readback data, registered.
- err_stb  out  1  one-cycle pulse per failed packet.

## Operation
- Settings registers, all reset to 0:
  - SR_BASE+0 CTRL: [0] enable, [1] clear (self-clearing pulse, zeroes counters and flags), [2] chk_seq, [3] chk_sid.
  - +1 EXP_SID[31:0].
  - +2 EXP_WORDS[15:0], payload words per packet.
  - +3 STEP[31:0], zero-extended to 64.
- Header word layout: [63:62] type, [61] has_time, [60] eob, [59:48] seqnum, [47:32] length in bytes, [31:0] SID.
- FSM states:
  - HDR: on a header beat, go to TIME if has_time, else PAYLOAD. If the header beat also carries tlast, evaluate immediately with a length error.
  - TIME: timestamp word is ignored, then go to PAYLOAD.
  - PAYLOAD: word index k counts from 0. Expected value = k*STEP (64-bit, wraps mod 2^64). On tlast, evaluate and return to HDR.
- Per-packet checks. Errors are sticky within the packet, and a packet increments err_count at most once.
  - LEN: payload word count ≠ EXP_WORDS, or length field ≠ 8*(1+has_time+EXP_WORDS) (16-bit arithmetic).
  - SID: enabled by chk_sid; header SID ≠ EXP_SID.
  - SEQ: enabled by chk_seq; seqnum ≠ previous seqnum+1 mod 4096. The first packet after enable or clear only seeds the check.
  - DATA: any payload word ≠ expected value. First mismatching index k is captured, saturating at 0xFFFF.
- Gating and counters:
  - enable, chk_seq and chk_sid are sampled on the header beat; mid-packet changes take effect at the next packet.
  - With enable=0, beats are consumed but counters and flags do not change.
  - pkt_count and err_count are 32-bit and saturate at 0xFFFFFFFF.
- rb_addr selection:
  - 0: {32'0, pkt_count}.
  - 1: {32'0, err_count}.
  - 2: {44'0, last_err_flags[3:0] {DATA,SEQ,SID,LEN}, first_bad_idx[15:0]}.
  - 3: {last_hdr_word}.

## Timing
- Reset values: i_tready=0, rb_data=0, err_stb=0, FSM=HDR, all counters, flags and registers 0.
- i_tready rises the first bus_clk edge after reset deassertion and then stays 1; the block never back-pressures.
- Counters, flags and err_stb update on the edge after the tlast beat (1-cycle latency). rb_data reflects the update one further cycle later.
- A clear strobe on the same cycle as a packet evaluation wins: counters end at 0, and the evaluated packet is discarded.
- Reset mid-packet returns the FSM to HDR. The remainder of the packet is then treated as a new packet and fails LEN; this is the expected behaviour.
- Back-to-back packets with no idle cycle between tlast and the next header are supported at full rate.

## Structure
- Shared package cvita_chk_pkg holds:
  - header field bit positions;
  - the SR offset constants CTRL/EXP_SID/EXP_WORDS/STEP;
  - the error-flag bit indices;
  - the FSM state enum.
- One sub-module, sat_counter32: increments, synchronous clear, saturates. It is instantiated for pkt_count and err_count.

## Test plan
- **Clean run:** EXP_WORDS=16, STEP=0x100, ramp from 0, 10 packets, no timestamp → pkt_count=10, err_count=0, err_stb never pulses.
- **Payload corruption:** corrupt word 5 of packet 3 → err_count=1, flags=DATA, first_bad_idx=5, and a single err_stb pulse.
- **Length errors:**
  - a 15-word packet, and a packet with length field 0x90 instead of 0x88 → err_count=2, LEN set both times;
  - a 1-beat packet (tlast on header) → LEN.
- **SID and sequence:** chk_sid=1, EXP_SID=0x12345678, SIDs matching. Seqnums 0xFFE, 0xFFF, 0x000 pass; 0x002 then fails SEQ only.
- **Timestamp and back-to-back:** has_time=1, length 0x90, packets back-to-back with tvalid held high → all pass, i_tready never deasserts.
- **Clear and reset:**
  - clear coincident with a tlast evaluation → counters read 0;
  - bus_rst_n low mid-packet → outputs at reset values;
  - after release, the next full packet passes and the truncated tail counts one LEN error.
